// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg-timer countdown datapath.
package egg_timer_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned SEC_TENS_MAX = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        DONE
    } timerState_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown borrow chain; wraps 0 -> MAX when borrowed from.
module bcd_down_digit
    import egg_timer_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] nextDigit,
    output logic               borrow_out
);

    always_comb begin
        borrow_out = borrow_in && (digit == '0);
        if (!borrow_in)
            nextDigit = digit;
        else if (digit == '0)
            nextDigit = DIGIT_W'(MAX);
        else
            nextDigit = digit - 1'b1;
    end

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS packed-BCD countdown with internal one-second prescaler, run/pause/done
// control, load validation and one-cycle alarm / load-error pulses.
module countdown_timer_mmss
    import egg_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned MIN_DIGITS = 2,
    parameter int unsigned TW         = 4 * (MIN_DIGITS + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          writeEnable,
    input  logic          start,
    input  logic          pause,
    input  logic [TW-1:0] inputTime,
    output logic [TW-1:0] outputTime,
    output logic          isZero,
    output logic          running,
    output logic          done,
    output logic          alarm,
    output logic          loadError
);

    localparam int unsigned ND = MIN_DIGITS + 2;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    timerState_t   state, stateNext;
    logic [TW-1:0] timeQ, timeNext, decTime;
    logic [PW-1:0] preQ, preNext;
    logic          alarmQ, alarmNext;
    logic          loadErrQ, loadErrNext;
    logic [ND:0]   borrow;
    logic          loadValid;
    logic          tick;

    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < ND; g++) begin : gDigit
        bcd_down_digit #(
            .MAX((g == 1) ? SEC_TENS_MAX : 9)
        ) uDigit (
            .digit      (timeQ[g*DIGIT_W +: DIGIT_W]),
            .borrow_in  (borrow[g]),
            .nextDigit  (decTime[g*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow[g+1])
        );
    end

    always_comb begin
        loadValid = 1'b1;
        for (int unsigned i = 0; i < ND; i++) begin
            if (inputTime[i*DIGIT_W +: DIGIT_W] > 4'd9)
                loadValid = 1'b0;
        end
        if (inputTime[DIGIT_W +: DIGIT_W] > DIGIT_W'(SEC_TENS_MAX))
            loadValid = 1'b0;
    end

    assign tick = (preQ == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timeQ    <= '0;
            preQ     <= '0;
            alarmQ   <= 1'b0;
            loadErrQ <= 1'b0;
        end else begin
            state    <= stateNext;
            timeQ    <= timeNext;
            preQ     <= preNext;
            alarmQ   <= alarmNext;
            loadErrQ <= loadErrNext;
        end
    end

    // A write (accepted or rejected) consumes the edge: no tick or FSM move alongside it.
    always_comb begin
        stateNext   = state;
        timeNext    = timeQ;
        preNext     = preQ;
        alarmNext   = 1'b0;
        loadErrNext = 1'b0;
        if (writeEnable) begin
            if (loadValid) begin
                timeNext  = inputTime;
                stateNext = IDLE;
                preNext   = '0;
            end else begin
                loadErrNext = 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !pause && !isZero) begin
                        stateNext = RUNNING;
                        preNext   = '0;
                    end
                end
                RUNNING: begin
                    if (pause) begin
                        stateNext = PAUSED;
                    end else if (tick) begin
                        preNext = '0;
                        // The top borrow only appears on an underflow, which DONE prevents.
                        if (!borrow[ND])
                            timeNext = decTime;
                        if (timeQ == TW'(1)) begin
                            stateNext = DONE;
                            alarmNext = 1'b1;
                        end
                    end else begin
                        preNext = preQ + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start && !pause)
                        stateNext = RUNNING;
                end
                DONE: begin
                    stateNext = DONE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        outputTime = timeQ;
        isZero     = (timeQ == '0);
        running    = (state == RUNNING);
        done       = (state == DONE);
        alarm      = alarmQ;
        loadError  = loadErrQ;
    end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed plus randomized bench for countdown_timer_mmss against a seconds-based reference model.
module tb_countdown_timer_mmss;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        writeEnable = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] inputTime = '0;
    logic [15:0] outputTime;
    logic        isZero, running, done, alarm, loadError;

    int total = 0;
    int bad = 0;
    int alarms;

    typedef enum {S_IDLE, S_RUN, S_PAUSE, S_DONE} mState_t;
    mState_t mState;
    int      mSecs, mPre;
    bit      mAlarm, mLdErr;

    always #5 clk = ~clk;

    countdown_timer_mmss #(
        .TICK_DIV  (TD),
        .MIN_DIGITS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .writeEnable(writeEnable),
        .start      (start),
        .pause      (pause),
        .inputTime  (inputTime),
        .outputTime (outputTime),
        .isZero     (isZero),
        .running    (running),
        .done       (done),
        .alarm      (alarm),
        .loadError  (loadError)
    );

    function automatic logic [15:0] toBcd(int s);
        int m = s / 60;
        int r = s % 60;
        return 16'((m / 10) * 4096 + (m % 10) * 256 + (r / 10) * 16 + (r % 10));
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState = S_IDLE;
        mSecs  = 0;
        mPre   = 0;
        mAlarm = 0;
        mLdErr = 0;
    endtask

    task automatic modelEdge();
        int d[4];
        bit ok;
        mAlarm = 0;
        mLdErr = 0;
        if (writeEnable) begin
            ok = 1;
            for (int i = 0; i < 4; i++) begin
                d[i] = int'(inputTime >> (4 * i)) & 15;
                if (d[i] > 9) ok = 0;
            end
            if (d[1] > 5) ok = 0;
            if (ok) begin
                mSecs  = (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
                mState = S_IDLE;
                mPre   = 0;
            end else begin
                mLdErr = 1;
            end
        end else begin
            case (mState)
                S_IDLE:
                    if (start && !pause && mSecs > 0) begin
                        mState = S_RUN;
                        mPre   = 0;
                    end
                S_RUN:
                    if (pause) mState = S_PAUSE;
                    else if (mPre == TD - 1) begin
                        mPre  = 0;
                        mSecs = mSecs - 1;
                        if (mSecs == 0) begin
                            mState = S_DONE;
                            mAlarm = 1;
                        end
                    end else mPre++;
                S_PAUSE:
                    if (start && !pause) mState = S_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic checkAll(string tag);
        chk({tag, ".time"},    outputTime, toBcd(mSecs));
        chk({tag, ".isZero"},  16'(isZero),    16'(mSecs == 0));
        chk({tag, ".running"}, 16'(running),   16'(mState == S_RUN));
        chk({tag, ".done"},    16'(done),      16'(mState == S_DONE));
        chk({tag, ".alarm"},   16'(alarm),     16'(mAlarm));
        chk({tag, ".ldErr"},   16'(loadError), 16'(mLdErr));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll(tag);
    endtask

    task automatic load(logic [15:0] v, string tag);
        writeEnable = 1'b1;
        inputTime   = v;
        step(tag);
        writeEnable = 1'b0;
    endtask

    initial begin
        modelReset();
        #1 reset = 1'b0;
        #1 checkAll("reset");
        chk("reset.time", outputTime, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        load(16'h0034, "load34");
        chk("load34.value", outputTime, 16'h0034);
        chk("load34.isZero", 16'(isZero), 16'd0);

        load(16'h0100, "load100");
        start = 1'b1;
        step("go100");
        start = 1'b0;
        repeat (4) step("borrowA");
        chk("borrow.first", outputTime, 16'h0059);
        chk("borrow.running", 16'(running), 16'd1);
        repeat (4) step("borrowB");
        chk("borrow.second", outputTime, 16'h0058);

        load(16'h0002, "load2");
        start = 1'b1;
        step("go2");
        start = 1'b0;
        alarms = 0;
        for (int i = 0; i < 8; i++) begin
            step("finish");
            alarms += int'(alarm);
        end
        chk("finish.time", outputTime, 16'h0000);
        chk("finish.done", 16'(done), 16'd1);
        chk("finish.running", 16'(running), 16'd0);
        chk("finish.alarmCount", 16'(alarms), 16'd1);
        start = 1'b1;
        repeat (3) step("doneStart");
        chk("doneStart.done", 16'(done), 16'd1);
        start = 1'b0;

        load(16'h0010, "load10");
        start = 1'b1;
        step("go10");
        start = 1'b0;
        repeat (2) step("preRun");
        pause = 1'b1;
        repeat (10) step("paused");
        chk("paused.time", outputTime, 16'h0010);
        chk("paused.running", 16'(running), 16'd0);
        pause = 1'b0;
        start = 1'b1;
        step("resume");
        start = 1'b0;
        step("resume1");
        chk("resume1.time", outputTime, 16'h0010);
        step("resume2");
        chk("resume2.time", outputTime, 16'h0009);

        load(16'h0070, "bad70");
        chk("bad70.ldErr", 16'(loadError), 16'd1);
        chk("bad70.time", outputTime, 16'h0009);
        step("afterBad");
        chk("afterBad.ldErr", 16'(loadError), 16'd0);
        load(16'h1A05, "bad1A05");
        chk("bad1A05.ldErr", 16'(loadError), 16'd1);
        writeEnable = 1'b1;
        start       = 1'b1;
        pause       = 1'b1;
        inputTime   = 16'h0005;
        step("prio");
        writeEnable = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        chk("prio.time", outputTime, 16'h0005);
        chk("prio.running", 16'(running), 16'd0);
        step("prioIdle");

        load(16'h0005, "load5");
        start = 1'b1;
        step("go5");
        start = 1'b0;
        repeat (3) step("run5");
        #2 reset = 1'b0;
        #1 modelReset();
        checkAll("async");
        chk("async.time", outputTime, 16'h0000);
        #1 reset = 1'b1;
        start = 1'b1;
        repeat (3) step("postReset");
        chk("postReset.running", 16'(running), 16'd0);
        chk("postReset.isZero", 16'(isZero), 16'd1);
        start = 1'b0;

        repeat (400) begin
            writeEnable = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                inputTime = 16'($urandom);
            else
                inputTime = toBcd(int'($urandom_range(0, 1)) * 60 + int'($urandom_range(0, 15)));
            start = ($urandom_range(0, 3) != 0);
            pause = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer_mmss.md
Name: countdown_timer_mmss

Overview:
- Parametrised successor to the single 8-bit decrement-time register.
- Holds a minutes:seconds countdown value in packed BCD.
- Generates its own 1 Hz-equivalent decrement tick from clk via a prescaler, and provides run/pause/done control plus a one-cycle alarm pulse.
- Sits between the keypad/load logic and the display driver and buzzer in the egg-timer top level.

Parameters:
- TICK_DIV, default 50000000: clk cycles per one-second decrement. Must be at least 2.
- MIN_DIGITS, default 2: number of BCD minute digits (1..3). Seconds are always 2 digits, tens digit 0..5.
- TW, default 4*(MIN_DIGITS+2): derived BCD time width. Do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- writeEnable  in  1  load inputTime this cycle.
- start  in  1  begin or resume countdown (level, sampled each edge).
- pause  in  1  freeze countdown (level, sampled each edge).
- inputTime  in  TW  packed BCD load value {minutes, sec_tens, sec_units}.
- outputTime  out  TW  current BCD countdown value.
- isZero  out  1  outputTime == 0, combinational from the register.
- running  out  1  high in the RUNNING state.
- done  out  1  high in the DONE state.
- alarm  out  1  one-cycle pulse on entry to DONE.
- loadError  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (reset low, async): outputTime=0, state=IDLE, prescaler=0; alarm, loadError, running, done all 0.
- States and transitions:
  - IDLE: start && !pause && !isZero -> RUNNING; prescaler cleared.
  - RUNNING: pause -> PAUSED, prescaler held. Tick while outputTime==1 (00:01) -> value becomes 0, state -> DONE, alarm=1 for that cycle.
  - PAUSED: start && !pause -> RUNNING, prescaler resumes from its held count.
  - DONE: holds until writeEnable. start is ignored.
- Priority per edge: writeEnable > pause > start > tick.
- writeEnable in any state:
  - Digits are validated: every digit must be <=9 and sec_tens <=5.
  - Valid: outputTime=inputTime, state -> IDLE, prescaler=0.
  - Invalid: outputTime and state unchanged, loadError=1 for one cycle.
- Prescaler counts 0..TICK_DIV-1 only in RUNNING. On the edge where count==TICK_DIV-1, the decrement is applied and the count wraps to 0. The first decrement lands exactly TICK_DIV edges after the edge that entered RUNNING.
- Decrement is BCD with a borrow chain:
  - sec_units 0 -> 9, borrowing from sec_tens.
  - sec_tens 0 -> 5, borrowing from minutes units.
  - Minute digits 0 -> 9, borrowing upward.
  - Underflow below 0 never occurs, because DONE is entered at zero.
- Loading a valid zero value: state IDLE, isZero=1; start is ignored and alarm does not fire.
- Reset asserted mid-run aborts immediately. No alarm is produced.

Decomposition:
- Package egg_timer_pkg holds:
  - State enum {IDLE, RUNNING, PAUSED, DONE}.
  - BCD digit width constant (4).
  - Max seconds-tens constant (5).
- Sub-module bcd_down_digit: one digit with a MAX parameter (9 or 5). Inputs: digit, borrow_in. Outputs: next digit, borrow_out (borrow_out=1 when digit==0 && borrow_in). Combinational.
- Instantiate bcd_down_digit once per digit in a generate chain. The top holds the FSM, prescaler, registers and validation.

Test Plan (TICK_DIV=4, MIN_DIGITS=2):
- Basic load: reset, then write 00:34 (16'h0034) -> outputTime=0x0034 next edge, state IDLE, isZero=0.
- Borrow chain: write 01:00, start -> 4 edges later outputTime=0x0059; 4 more -> 0x0058; running=1 throughout.
- Completion: write 00:02, start -> after 8 edges outputTime=0, done=1, alarm high exactly 1 cycle, running=0. Further start has no effect.
- Pause/resume: write 00:10, start, pause after 2 edges for 10 cycles, then start -> first decrement to 0x0009 lands 2 edges after resume.
- Invalid load and priority: write 16'h0070 -> loadError pulse, value unchanged. Write 16'h1A05 -> rejected. writeEnable+start+pause in the same cycle with valid 0x0005 -> loaded, state IDLE.
- Async reset mid-run: write 00:05, start, drop reset between edges -> outputs 0 immediately, no alarm; after release, start is ignored (isZero).
